led_matrix_scan: RTL

Parametrised row-scan driver for red/green LED dot-matrix panels. It replaces the fixed 8×8 scanner with a configurable geometry, a per-row blanking interval against ghosting, 9-level global brightness by on-time modulation, and a double-buffered frame load that swaps only at frame boundaries. It sits between the picture-generating logic (game and status FSMs) and the panel pins.

---
 rtl/led_matrix_scan_pkg.sv | 25 ++
 rtl/led_matrix_scan_if.sv | 14 +
 rtl/led_matrix_scan_slot_timer.sv | 69 ++++++
 rtl/led_matrix_scan.sv | 102 ++++++++++
 4 files changed

// File: rtl/led_matrix_scan_pkg.sv
// Shared types and sizing helpers for the LED row-scan driver.
// Imported by the slot timer, the load interface and the top level.
package led_scan_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_LIT   = 1'b1
    } phase_e;

    localparam int MAX_LVL = 8;

    function automatic int cnt_w(input int slot);
        return (slot > 1) ? $clog2(slot) : 1;
    endfunction

    function automatic int row_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    // Brightness codes above MAX_LVL saturate to full duty.
    function automatic logic [3:0] clamp_lvl(input logic [3:0] b);
        return (b > 4'(MAX_LVL)) ? 4'(MAX_LVL) : b;
    endfunction

endpackage

// File: rtl/led_matrix_scan_if.sv
// Frame-load port between the picture generator (master) and the scanner (slave).
// A frame is taken when load and load_ready are both high on a clock edge.
interface led_matrix_scan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic [ROWS*COLS-1:0] pic_r;
    logic [ROWS*COLS-1:0] pic_g;
    logic                 load;
    logic                 load_ready;

    modport master (output pic_r, output pic_g, output load, input load_ready);
    modport slave  (input pic_r, input pic_g, input load, output load_ready);
endinterface

// File: rtl/led_matrix_scan_slot_timer.sv
// Row-slot timer: owns the in-slot counter, the row index and the blank/lit phase,
// and decodes the brightness step plus slot-start and frame-wrap strobes.
module led_slot_timer
    import led_scan_pkg::*;
#(
    parameter int BLANK = 4,
    parameter int STEP  = 32,
    parameter int ROWS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    output phase_e                   o_phase,
    output logic [2:0]               o_step,
    output logic [row_w(ROWS)-1:0]   o_row,
    output logic                     o_slot_start,
    output logic                     o_frame_wrap
);
    localparam int SLOT = BLANK + 8 * STEP;
    localparam int CW   = cnt_w(SLOT);
    localparam int RW   = row_w(ROWS);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [RW-1:0] r_row;
    logic [RW-1:0] w_row_nxt;
    phase_e        r_state;
    phase_e        w_state_nxt;
    logic          w_cnt_wrap;
    logic [CW-1:0] w_offset;

    assign w_cnt_wrap = (r_cnt == CW'(SLOT - 1));
    assign w_offset   = r_cnt - CW'(BLANK);

    // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_cnt_nxt   = r_cnt + CW'(1);
        w_row_nxt   = r_row;
        w_state_nxt = r_state;
        if (w_cnt_wrap) begin
            w_cnt_nxt = '0;
            w_row_nxt = (r_row == RW'(ROWS - 1)) ? '0 : r_row + RW'(1);
        end
        case (r_state)
            S_BLANK: if (w_cnt_nxt == CW'(BLANK)) w_state_nxt = S_LIT;
            S_LIT:   if (w_cnt_wrap)              w_state_nxt = S_BLANK;
            default:                              w_state_nxt = S_BLANK;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_row   <= '0;
            r_state <= S_BLANK;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign o_phase      = r_state;
    assign o_step       = (r_state == S_LIT) ? 3'(w_offset / CW'(STEP)) : 3'd0;
    assign o_row        = r_row;
    assign o_slot_start = (r_cnt == '0);
    assign o_frame_wrap = w_cnt_wrap && (r_row == RW'(ROWS - 1));

endmodule

// File: rtl/led_matrix_scan.sv
// Row-scan driver for red/green LED dot-matrix panels with per-row blanking,
// 9-level brightness and a double-buffered frame that swaps only at frame wrap.
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int BLANK = 4,
    parameter int STEP  = 32
) (
    input  logic                clk,
    input  logic                rst,
    led_matrix_scan_if.slave    frame_if,
    input  logic [3:0]          bright,
    output logic [ROWS-1:0]     n_row,
    output logic [COLS-1:0]     col_r,
    output logic [COLS-1:0]     col_g,
    output logic                frame_start
);
    localparam int RW = row_w(ROWS);

    typedef logic [ROWS-1:0][COLS-1:0] frame_t;

    frame_t        r_act_r;
    frame_t        r_act_g;
    frame_t        r_pend_r;
    frame_t        r_pend_g;
    logic          r_pend_v;
    logic [3:0]    r_lvl;

    phase_e        w_phase;
    logic [2:0]    w_step;
    logic [RW-1:0] w_row;
    logic          w_slot_start;
    logic          w_frame_wrap;
    logic          w_load_acc;
    logic          w_lit;

    led_slot_timer #(
        .BLANK (BLANK),
        .STEP  (STEP),
        .ROWS  (ROWS)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .o_phase      (w_phase),
        .o_step       (w_step),
        .o_row        (w_row),
        .o_slot_start (w_slot_start),
        .o_frame_wrap (w_frame_wrap)
    );

    assign frame_if.load_ready = !r_pend_v;
    assign w_load_acc          = frame_if.load && !r_pend_v;
    assign w_lit               = (w_phase == S_LIT) && ({1'b0, w_step} < r_lvl);

    // NOTE: the frame buffers are plain registers, so they are cleared by reset and power up dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_r  <= '0;
            r_act_g  <= '0;
            r_pend_r <= '0;
            r_pend_g <= '0;
            r_pend_v <= 1'b0;
        end else begin
            // A swap cycle always sees pend_v high, so it can never coincide with a load.
            if (w_frame_wrap && r_pend_v) begin
                r_act_r  <= r_pend_r;
                r_act_g  <= r_pend_g;
                r_pend_v <= 1'b0;
            end else if (w_load_acc) begin
                r_pend_r <= frame_if.pic_r;
                r_pend_g <= frame_if.pic_g;
                r_pend_v <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl <= '0;
        end else if (w_slot_start) begin
            r_lvl <= clamp_lvl(bright);
        end
    end

    // Outputs are the registered decode of the current counter position.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_row       <= '1;
            col_r       <= '0;
            col_g       <= '0;
            frame_start <= 1'b0;
        end else begin
            n_row       <= (w_phase == S_LIT) ? ~(ROWS'(1) << w_row) : '1;
            col_r       <= w_lit ? r_act_r[w_row] : '0;
            col_g       <= w_lit ? r_act_g[w_row] : '0;
            frame_start <= w_slot_start && (w_row == '0);
        end
    end

endmodule
